// File: rtl/jtframe_dwnld_buf.sv
// ROM download buffer: maps the ioctl byte stream onto banked SDRAM word writes
// through a small FIFO, and holds dwnld_busy until the last write has settled.
module jtframe_dwnld_buf #(
  parameter logic [24:0] BA1_START   = 25'h10_0000,
  parameter logic [24:0] BA2_START   = 25'h18_0000,
  parameter logic [24:0] BA3_START   = 25'h1C_0000,
  parameter logic [24:0] ROM_END     = 25'h20_0000,
  parameter int unsigned FIFO_AW     = 2,
  parameter int unsigned POST_CYCLES = 8
) (
  input  logic        clk_rom,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_data,
  input  logic        ioctl_wr,
  output logic [21:0] prog_addr,
  output logic [7:0]  prog_data,
  output logic [1:0]  prog_mask,
  output logic [1:0]  prog_bank,
  output logic        prog_we,
  output logic        prog_rd,
  input  logic        prog_rdy,
  output logic        dwnld_busy,
  output logic        overflow
);

  localparam int unsigned Depth  = 1 << FIFO_AW;
  localparam int unsigned EntryW = 34;
  localparam int unsigned PostW  = $clog2(POST_CYCLES + 1);
  localparam logic [PostW-1:0]   PostMax = PostW'(POST_CYCLES);
  localparam logic [FIFO_AW:0]   CntFull = (FIFO_AW + 1)'(Depth);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e state_q, state_d;

  logic [EntryW-1:0]  mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               full, empty, wr_req, push, pop;

  logic               discard;
  logic [1:0]         bank;
  logic [22:0]        start, off;
  logic [EntryW-1:0]  entry;

  logic               busy_q, busy_d, overflow_q, quiet;
  logic [PostW-1:0]   post_q, post_d;

  // Only the low 23 bits of the offset matter, so the subtraction is done at that width.
  always_comb begin
    discard = (ioctl_addr >= ROM_END);
    if (ioctl_addr >= BA3_START) begin
      bank  = 2'd3;
      start = BA3_START[22:0];
    end else if (ioctl_addr >= BA2_START) begin
      bank  = 2'd2;
      start = BA2_START[22:0];
    end else if (ioctl_addr >= BA1_START) begin
      bank  = 2'd1;
      start = BA1_START[22:0];
    end else begin
      bank  = 2'd0;
      start = 23'd0;
    end
    off   = ioctl_addr[22:0] - start;
    entry = {bank, off[22:1], (off[0] ? 2'b01 : 2'b10), ioctl_data};
  end

  assign full   = (cnt_q == CntFull);
  assign empty  = (cnt_q == '0);
  assign wr_req = ioctl_wr & downloading & ~discard;
  assign push   = wr_req & ~full;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_rom) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_q | (wr_req & full);
    end
  end

  // FSM state register
  always_ff @(posedge clk_rom) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StWait;
      StWait:  if (prog_rdy && empty) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A pop in WAIT reloads the output registers so writes run back to back.
  always_comb begin
    prog_we = (state_q == StWait);
    pop     = ~empty & ((state_q == StIdle) | prog_rdy);
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      prog_bank <= '0;
      prog_addr <= '0;
      prog_mask <= '0;
      prog_data <= '0;
    end else if (pop) begin
      {prog_bank, prog_addr, prog_mask, prog_data} <= mem_q[rd_ptr_q];
    end
  end

  assign quiet = ~downloading & empty & (state_q == StIdle);

  always_comb begin
    if (!quiet)                post_d = '0;
    else if (post_q == PostMax) post_d = post_q;
    else                        post_d = post_q + 1'b1;
    busy_d = downloading | (busy_q & ~(quiet & (post_d == PostMax)));
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      post_q <= '0;
    end else begin
      busy_q <= busy_d;
      post_q <= post_d;
    end
  end

  assign prog_rd    = 1'b0;
  assign dwnld_busy = busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_jtframe_dwnld_buf.sv
// Directed bench for jtframe_dwnld_buf: bank decode, FIFO overflow, back-to-back
// writes, busy countdown and reset abort, with hand-computed expectations.
module tb_jtframe_dwnld_buf;

  logic        clk_rom = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_bank;
  logic        prog_we;
  logic        prog_rd;
  logic        prog_rdy;
  logic        dwnld_busy;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;

  jtframe_dwnld_buf dut (
    .clk_rom     (clk_rom),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_data  (ioctl_data),
    .ioctl_wr    (ioctl_wr),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_bank   (prog_bank),
    .prog_we     (prog_we),
    .prog_rd     (prog_rd),
    .prog_rdy    (prog_rdy),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  always #5 clk_rom = ~clk_rom;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_rom);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_data = data;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [1:0] bank,
                              input logic [21:0] addr, input logic [1:0] mask,
                              input logic [7:0] data);
    int n = 0;
    while (prog_we !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, ".we"},   32'(prog_we),   32'd1);
    check({tag, ".bank"}, 32'(prog_bank), 32'(bank));
    check({tag, ".addr"}, 32'(prog_addr), 32'(addr));
    check({tag, ".mask"}, 32'(prog_mask), 32'(mask));
    check({tag, ".data"}, 32'(prog_data), 32'(data));
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (prog_we === 1'b1) seen++;
      step();
    end
    if (prog_we === 1'b1) seen++;
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    downloading = 1'b0;
    ioctl_addr  = '0;
    ioctl_data  = '0;
    ioctl_wr    = 1'b0;
    prog_rdy    = 1'b0;
    step();
    step();
    check("rst.we",   32'(prog_we),    32'd0);
    check("rst.busy", 32'(dwnld_busy), 32'd0);
    check("rst.ovf",  32'(overflow),   32'd0);
    check("rst.addr", 32'(prog_addr),  32'd0);
    check("rst.rd",   32'(prog_rd),    32'd0);
    rst_n = 1'b1;
    downloading = 1'b1;
    step();
    check("busy.set", 32'(dwnld_busy), 32'd1);

    // Single byte: latency and field mapping
    ioctl_addr = 25'h000003;
    ioctl_data = 8'h5A;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr = 1'b0;
    check("t2.we_n1", 32'(prog_we),   32'd0);
    step();
    check("t2.we_n2", 32'(prog_we),   32'd1);
    check("t2.addr",  32'(prog_addr), 32'd1);
    check("t2.mask",  32'(prog_mask), 32'b01);
    check("t2.bank",  32'(prog_bank), 32'd0);
    check("t2.data",  32'(prog_data), 32'h5A);
    step();
    step();
    check("t2.we_held", 32'(prog_we), 32'd1);
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
    check("t2.we_drop", 32'(prog_we), 32'd0);

    // Bank decode and discard above ROM_END
    write_byte(25'h100000, 8'h11);
    write_byte(25'h180001, 8'h22);
    write_byte(25'h1C0004, 8'h33);
    write_byte(25'h200000, 8'h44);
    expect_write("t3.b1", 2'd1, 22'd0, 2'b10, 8'h11);
    expect_write("t3.b2", 2'd2, 22'd0, 2'b01, 8'h22);
    expect_write("t3.b3", 2'd3, 22'd2, 2'b10, 8'h33);
    expect_quiet("t3.discard", 10);
    check("t3.ovf", 32'(overflow), 32'd0);

    // Overflow with prog_rdy withheld, then back-to-back drain
    for (int i = 0; i < 6; i++) write_byte(25'(i), 8'hA0 + 8'(i));
    step();
    check("t4.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t4.we%0d", i),   32'(prog_we),   32'd1);
      check($sformatf("t4.data%0d", i), 32'(prog_data), 32'hA0 + 32'(i));
      check($sformatf("t4.addr%0d", i), 32'(prog_addr), 32'(i / 2));
      check($sformatf("t4.mask%0d", i), 32'(prog_mask), (i % 2 == 1) ? 32'b01 : 32'b10);
      prog_rdy = 1'b1;
      step();
    end
    prog_rdy = 1'b0;
    check("t4.we_end", 32'(prog_we), 32'd0);
    expect_quiet("t4.no_sixth", 6);
    check("t4.ovf_sticky", 32'(overflow), 32'd1);

    // downloading falls with two entries still queued behind the output register
    for (int i = 0; i < 3; i++) write_byte(25'h10 + 25'(i), 8'hC0 + 8'(i));
    downloading = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("t5.busy_q%0d", i), 32'(dwnld_busy), 32'd1);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5.data%0d", i), 32'(prog_data), 32'hC0 + 32'(i));
      prog_rdy = 1'b1;
      step();
      prog_rdy = 1'b0;
    end
    check("t5.we_end", 32'(prog_we),    32'd0);
    check("t5.busy_a", 32'(dwnld_busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("t5.post%0d", i), 32'(dwnld_busy), 32'd1);
    end
    step();
    check("t5.busy_clr", 32'(dwnld_busy), 32'd0);

    // Re-asserted downloading during the countdown restarts it without a gap
    downloading = 1'b1;
    step();
    check("t5.rebusy", 32'(dwnld_busy), 32'd1);
    downloading = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t5.cd%0d", i), 32'(dwnld_busy), 32'd1);
    end
    downloading = 1'b1;
    step();
    check("t5.rise", 32'(dwnld_busy), 32'd1);
    downloading = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("t5.cd2_%0d", i), 32'(dwnld_busy), 32'd1);
    end
    step();
    check("t5.busy_clr2", 32'(dwnld_busy), 32'd0);

    // Reset while in WAIT with three entries queued
    downloading = 1'b1;
    step();
    for (int i = 0; i < 4; i++) write_byte(25'h20 + 25'(i), 8'hE0 + 8'(i));
    step();
    check("t6.we_pre", 32'(prog_we), 32'd1);
    rst_n = 1'b0;
    step();
    check("t6.we",   32'(prog_we),    32'd0);
    check("t6.busy", 32'(dwnld_busy), 32'd0);
    check("t6.ovf",  32'(overflow),   32'd0);
    check("t6.addr", 32'(prog_addr),  32'd0);
    rst_n = 1'b1;
    expect_quiet("t6.flushed", 10);
    write_byte(25'h000031, 8'h77);
    expect_write("t6.new", 2'd0, 22'h18, 2'b01, 8'h77);
    expect_quiet("t6.empty", 8);
    downloading = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
